// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// bit_serializer: MSB-first parallel-to-serial front end with a valid/ready input.
// Define SER_PARITY_EN to append an even-parity bit to every word.  Rev 1.0
// ============================================================================
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef SER_PARITY_EN
  localparam int LAST_INT = WIDTH;
`else
  localparam int LAST_INT = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST_INT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             serial_out_q, serial_out_d;
  logic             serial_valid_q, serial_valid_d;
  logic             word_done_q, word_done_d;
  logic             last_bit;
  logic             xfer;
  logic             fill;

`ifdef SER_PARITY_EN
  logic parity_q, parity_d;
  // The parity bit is shifted in behind the data so it surfaces at the MSB last.
  assign fill = parity_q;
`else
  assign fill = 1'b0;
`endif

  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign data_ready = (state_q == IDLE) || last_bit;
  assign xfer       = data_valid && data_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
`ifdef SER_PARITY_EN
    parity_d = parity_q;
`endif
    if (xfer) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = data_in;
`ifdef SER_PARITY_EN
      parity_d = ^data_in;
`endif
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
        sr_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sr_d  = {sr_q[WIDTH-2:0], fill};
      end
    end
  end

  // Outputs are registered from next-state so they line up with the shifted word.
  always_comb begin
    serial_valid_d = (state_d == SHIFT);
    serial_out_d   = serial_valid_d && sr_d[WIDTH-1];
    word_done_d    = serial_valid_d && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sr_q           <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      word_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sr_q           <= sr_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      word_done_q    <= word_done_d;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign word_done    = word_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// Testbench for bit_serializer: directed and random words against a bit-queue model.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         serial_out;
  logic         serial_valid;
  logic         word_done;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic b;
    logic last;
  } bit_t;

  // Front entry is the bit on the wire in the current cycle.
  bit_t q[$];

  bit_serializer #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .word_done   (word_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    bit_t e;
    logic par;
    par = ^d;
    for (int i = W - 1; i >= 0; i--) begin
      e.b = d[i];
`ifdef SER_PARITY_EN
      e.last = 1'b0;
`else
      e.last = (i == 0);
`endif
      q.push_back(e);
    end
`ifdef SER_PARITY_EN
    e.b    = par;
    e.last = 1'b1;
    q.push_back(e);
`endif
  endtask

  task automatic check_outputs(input string tag);
    logic ev, eb, ed, er;
    ev = (q.size() > 0);
    eb = ev ? q[0].b : 1'b0;
    ed = ev ? q[0].last : 1'b0;
    er = (q.size() <= 1);
    chk({tag, ".serial_valid"}, serial_valid, ev);
    chk({tag, ".serial_out"},   serial_out,   eb);
    chk({tag, ".word_done"},    word_done,    ed);
    chk({tag, ".data_ready"},   data_ready,   er);
  endtask

  // One clock: drive at negedge, update the model at posedge, check at next negedge.
  task automatic cyc(input string tag, input logic v, input logic [W-1:0] d);
    logic ready_exp;
    data_valid = v;
    data_in    = d;
    ready_exp  = (q.size() <= 1);
    @(posedge clock);
    if (q.size() > 0) q.pop_front();
    if (v && ready_exp) push_word(d);
    @(negedge clock);
    check_outputs(tag);
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 8'h00);
  endtask

  initial begin
    reset      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    #2;
    check_outputs("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    check_outputs("release");

    // Idle with no requests
    drain("idle", 20);

    // Single word; first transfer right after release is covered by idle above
    cyc("e0", 1'b1, 8'hE0);
    drain("e0", W + 3);

    // Back-to-back FF then 0F
    cyc("b2b", 1'b1, 8'hFF);
    for (int i = 0; i < W + 1; i++) cyc("b2b", 1'b1, 8'h0F);
    drain("b2b", W + 3);

    // Hold while busy: A5 offered, replaced by 3C before the last-bit cycle
    cyc("hold", 1'b1, 8'h11);
    for (int i = 0; i < 4; i++) cyc("hold", 1'b1, 8'hA5);
    for (int i = 0; i < W; i++) begin
      cyc("hold", 1'b1, 8'h3C);
      if (q.size() > W - 1 && i > 0) break;
    end
    drain("hold", W + 3);

    // Reset in the middle of FF
    cyc("rst", 1'b1, 8'hFF);
    drain("rst", 3);
    reset = 1'b0;
    #1;
    q.delete();
    check_outputs("rst_async");
    @(negedge clock);
    data_valid = 1'b1;
    data_in    = 8'hFF;
    @(negedge clock);
    check_outputs("rst_hold");
    data_valid = 1'b0;
    reset = 1'b1;
    drain("rst_after", W + 2);

`ifdef SER_PARITY_EN
    cyc("par", 1'b1, 8'h07);
    for (int i = 0; i < W + 1; i++) cyc("par", 1'b1, 8'h03);
    drain("par", W + 3);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 3) != 0), W'($urandom));
    end
    drain("rnd_end", W + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream sequence detector. It accepts a WIDTH-bit word through a valid/ready handshake and presents it MSB-first, one bit per clock, on `serial_out`, which drives the detector's `in` port. `serial_valid` qualifies each bit. Back-to-back words stream with no idle cycle between them.

## Interface
- `WIDTH`, default 8: word width in bits; legal range ≥ 2.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  WIDTH  parallel word; sampled only on an accepted transfer.
- `data_valid`  in  1  upstream holds a word on `data_in`.
- `data_ready`  out  1  serializer can accept a word this cycle.
- `serial_out`  out  1  current serial bit; MSB first.
- `serial_valid`  out  1  `serial_out` carries a valid bit this cycle.
- `word_done`  out  1  one-cycle pulse, coincident with the final bit of a word.

## Operation
- Transfer occurs on a rising edge where `data_valid && data_ready`. `data_in` is captured into the shift register on that edge.
- States:
  - IDLE: `serial_valid`=0; `serial_out`=0; `data_ready`=1.
  - SHIFT: the word is being emitted.
- IDLE → SHIFT on a transfer.
- In SHIFT, `serial_out` is the shift-register MSB. The register shifts left by one each edge, and the bit counter (⌈log2(WIDTH+2)⌉ bits) increments.
- Last-bit cycle of SHIFT: `data_ready`=1 and `word_done`=1.
  - If a transfer occurs, load the new word and stay in SHIFT. The counter restarts, and the new MSB appears the next cycle with no gap.
  - If no transfer occurs, go to IDLE.
- `data_ready`=0 in every other SHIFT cycle. Upstream must hold `data_valid`/`data_in` until accepted. Changes to `data_in` outside a transfer edge have no effect.
- `data_ready` is combinational from state and counter only, never from `data_valid`.
- `serial_out`, `serial_valid` and `word_done` are registered outputs.

## Timing
- Reset asserted (`reset`=0), effective immediately and asynchronously:
  - state=IDLE, counter=0, shift register=0.
  - `serial_out`=0, `serial_valid`=0, `word_done`=0, `data_ready`=1.
- Reset mid-word aborts the word. Remaining bits are discarded and are never emitted after release.
- Latency: a word accepted at edge k has its MSB valid in the cycle after edge k. Bit i (MSB=0) is valid in cycle k+1+i.
- A word occupies exactly WIDTH valid cycles, or WIDTH+1 with parity (see Configuration).
- `word_done` is high only in the final-bit cycle of each word.
- Sustained `data_valid`=1 yields continuous `serial_valid`=1 at 1 bit/clock.
- The first transfer can occur on the first rising edge after reset release.

## Configuration
- `SER_PARITY_EN` defined:
  - Each word is followed by one extra serial bit equal to the XOR of all WIDTH data bits (even parity), computed at load.
  - The parity cycle is the last-bit cycle, so `word_done` and back-to-back `data_ready` move to it.
- `SER_PARITY_EN` undefined: no parity bit is emitted, and the last data bit is the last-bit cycle.
- Port list is identical in both builds.

## Test plan
- Single word, WIDTH=8, no parity: after reset release, transfer 8'hE0.
  - Required: `serial_out` = 1,1,1,0,0,0,0,0 over 8 consecutive cycles with `serial_valid`=1.
  - `word_done` high only on the 8th bit.
  - Return to IDLE with `serial_valid`=0 and `data_ready`=1.
- Back-to-back: hold `data_valid`=1 with 8'hFF, then 8'h0F presented immediately after the first is accepted.
  - Required: 16 consecutive valid bits, 1×8 then 0000_1111, with no idle gap.
  - `data_ready` high only in the first-accept cycle and in bit-8 cycles.
- Hold while busy: present 8'hA5 while a word is mid-shift.
  - Required: 8'hA5 is not accepted until the last-bit cycle.
  - Changing `data_in` to 8'h3C before then causes 8'h3C to be emitted, not 8'hA5.
- Reset mid-word: assert `reset`=0 at bit 4 of 8'hFF.
  - Required: all outputs go to reset values immediately and `data_ready`=1.
  - No residual 1s appear after release.
- Parity build (`SER_PARITY_EN`): transfer 8'h07, then 8'h03.
  - Required: 9 bits 0000_0111 then parity 1, followed by 0000_0011 then parity 0.
  - `word_done` on each 9th bit.
- Idle: `data_valid`=0 for 20 cycles after reset.
  - Required: `serial_valid`=0, `serial_out`=0 and `data_ready`=1 throughout.
